mode_fade_ctrl: RTL
===================

# mode_fade_ctrl

Mode-change sequencer and DAC output stage for the DDS signal chain. It owns the 3-bit mode select that drives the output multiplexer (sin / AM / FM / AM-demod / FM-demod) and consumes the multiplexer's registered 16-bit output. Each mode change is wrapped in a gain fade-out, switch, settle and fade-in sequence, so the DAC never sees a hard discontinuity. The scaled result is converted to 14-bit offset-binary DAC data.

## Interface
Parameters:
- STEP_CYC, 4: clock cycles per 1-LSB gain step (≥1); a full fade is 256·STEP_CYC cycles.
- SETTLE_CYC, 4: cycles held at zero gain after the mode update (≥2, covers multiplexer register latency).

Ports:
- clk_100M  in  1  system clock, 100 MHz.
- rst_n  in  1  reset: asynchronous assert, active-low.
- mode_req  in  3  requested mode, quasi-static (from key/UART control); valid codes 0–4.
- sig_in  in  16  signed two's-complement sample from the output multiplexer.
- mode  out  3  registered mode select to the output multiplexer.
- dac_data  out  14  offset-binary DAC word.
- busy  out  1  high while any fade/switch sequence is in progress.

## Operation
- State machine: RUN, FADE_OUT, SWITCH, FADE_IN. Internal registers: gain (9 bit, 0..256), target (3 bit), step counter, settle counter.
- Reset values: mode=0, target=0, gain=256, state=RUN, busy=0, dac_data=14'h2000 (midscale), pipeline registers=0.
- RUN: if mode_req ≤ 4 and mode_req ≠ mode, then latch target=mode_req, go to FADE_OUT, and set busy=1. Codes 5–7 are ignored in every state.
- FADE_OUT: gain decrements by 1 every STEP_CYC cycles. target re-latches any valid mode_req each cycle. When gain reaches 0, go to SWITCH.
- SWITCH: on entry, mode ← target. Gain is held at 0 for SETTLE_CYC cycles, then go to FADE_IN.
- FADE_IN: gain increments by 1 every STEP_CYC cycles. At gain=256, go to RUN and set busy=0 in the same cycle.
  - If a valid mode_req ≠ mode arrives during FADE_IN, latch target and go to FADE_OUT from the current gain. There is no jump.
- If target == mode at SWITCH (the request reverted during fade-out), the full settle/fade-in still executes. mode is rewritten with its own value, so no glitch results.
- Datapath:
  - product = sig_in × {1'b0, gain}, signed 26 bit.
  - scaled = product >>> 8, keeping bits [23:8]. This cannot overflow because gain ≤ 256.
  - dac_data = {~scaled[15], scaled[14:2]}, i.e. truncation, no rounding.
- Step counter resets to 0 on every state transition. The first gain step occurs STEP_CYC cycles after entering a FADE state.

## Timing
- dac_data latency: 2 cycles from sig_in.
  - Stage 1 registers the product using the gain value present in the same cycle as sig_in.
  - Stage 2 registers the offset-binary conversion.
- mode updates on the clock edge entering SWITCH. The multiplexer output reflects it 1 cycle later, and it reaches dac_data 3 cycles later, during which gain is 0.
- Total sequence, RUN to RUN with no interruption: 256·STEP_CYC + SETTLE_CYC + 256·STEP_CYC cycles (default 2052). busy is high for exactly that span, starting the cycle after mode_req is sampled.
- At gain=0, dac_data = 14'h2000 for any sig_in. At gain=256, dac_data is sig_in[15:2] with the MSB inverted.
- Reset mid-sequence: all registers return to reset values immediately (asynchronous), and mode returns to 0.

## Structure
- Shared package dds_pkg holds:
  - mode encodings MODE_SIN=0, MODE_AM=1, MODE_FM=2, MODE_AMDE=3, MODE_FMDE=4, MODE_MAX=4;
  - GAIN_ONE=256;
  - DAC_MID=14'h2000;
  - the state enum.
- One sub-module, gain_scaler: the 2-stage multiply / shift / offset-binary pipeline (sig_in, gain → dac_data). The FSM and counters stay in mode_fade_ctrl.

## Test plan
- Reset, then sig_in=16'h7FFF and mode_req=0 held → mode=0, busy=0, dac_data=14'h3FFF two cycles after release.
- mode_req 0→2 with STEP_CYC=1, SETTLE_CYC=4 → busy high for 516 cycles. mode becomes 2 exactly 256 cycles after busy rises, and dac_data=14'h2000 throughout SWITCH.
- sig_in=16'h8000, gain forced path to 128 mid-fade → dac_data=14'h1000 (−16384 scaled), verifying arithmetic shift and truncation.
- During FADE_IN at gain≈100, mode_req→3 → FADE_OUT resumes from the same gain with no step larger than 1 LSB, and mode ends at 3.
- mode_req=6 in RUN and mid-FADE_OUT → ignored. No sequence starts and target is unchanged.
- Assert rst_n low during FADE_OUT → mode=0, busy=0, dac_data=14'h2000 asynchronously. After release, RUN with gain=256.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared constants for the DDS output chain: multiplexer mode codes, unity gain,
// DAC midscale and the mode-fade sequencer state encoding.
package dds_pkg;

  localparam logic [2:0] MODE_SIN  = 3'd0;
  localparam logic [2:0] MODE_AM   = 3'd1;
  localparam logic [2:0] MODE_FM   = 3'd2;
  localparam logic [2:0] MODE_AMDE = 3'd3;
  localparam logic [2:0] MODE_FMDE = 3'd4;
  localparam logic [2:0] MODE_MAX  = 3'd4;

  localparam logic [8:0]  GAIN_ONE = 9'd256;
  localparam logic [13:0] DAC_MID  = 14'h2000;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FADE_OUT,
    ST_SWITCH,
    ST_FADE_IN
  } fade_state_e;

  // Codes above MODE_MAX are unused multiplexer inputs and must never be selected.
  function automatic logic mode_is_valid(input logic [2:0] m);
    return (m <= MODE_MAX);
  endfunction

endpackage

// File: rtl/gain_scaler.sv
// Gain multiply, arithmetic >>8 and offset-binary conversion for the DAC.
// Latency 2 cycles from sig_in/gain to dac_data; free-running, no backpressure.
module gain_scaler
  import dds_pkg::*;
(
  input  logic        clk_100M,
  input  logic        rst_n,
  input  logic [15:0] sig_in,
  input  logic [8:0]  gain,
  output logic [13:0] dac_data
);

  logic signed [25:0] sig_ext;
  logic signed [25:0] gain_ext;
  logic signed [25:0] product;
  logic [15:0]        scaled_d, scaled_q;
  logic [13:0]        dac_d, dac_q;
  logic               unused_bits;

  always_comb begin
    sig_ext  = {{10{sig_in[15]}}, sig_in};
    gain_ext = {17'd0, gain};
    product  = sig_ext * gain_ext;
    // gain never exceeds 256, so bits [23:8] hold the full shifted result.
    scaled_d = product[23:8];
    dac_d    = {~scaled_q[15], scaled_q[14:2]};
  end

  assign unused_bits = ^{product[25:24], product[7:0], scaled_q[1:0]};

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      scaled_q <= '0;
      dac_q    <= DAC_MID;
    end else begin
      scaled_q <= scaled_d;
      dac_q    <= dac_d;
    end
  end

  assign dac_data = dac_q;

endmodule

// File: rtl/mode_fade_ctrl.sv
// Mode-change sequencer: fades gain to zero, switches the multiplexer mode, settles,
// then fades back in; dac_data trails sig_in by 2 cycles, no backpressure.
module mode_fade_ctrl
  import dds_pkg::*;
#(
  parameter int STEP_CYC   = 4,
  parameter int SETTLE_CYC = 4
) (
  input  logic        clk_100M,
  input  logic        rst_n,
  input  logic [2:0]  mode_req,
  input  logic [15:0] sig_in,
  output logic [2:0]  mode,
  output logic [13:0] dac_data,
  output logic        busy
);

  localparam logic [15:0] STEP_LAST   = 16'(STEP_CYC - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);

  fade_state_e state_d, state_q;
  logic [8:0]  gain_d, gain_q;
  logic [2:0]  target_d, target_q;
  logic [2:0]  mode_d, mode_q;
  logic [15:0] step_cnt_d, step_cnt_q;
  logic [15:0] settle_cnt_d, settle_cnt_q;
  logic        req_valid;
  logic        step_now;

  always_comb begin
    state_d      = state_q;
    gain_d       = gain_q;
    target_d     = target_q;
    mode_d       = mode_q;
    step_cnt_d   = '0;
    settle_cnt_d = '0;
    req_valid    = mode_is_valid(mode_req);
    step_now     = (step_cnt_q == STEP_LAST);

    unique case (state_q)
      ST_RUN: begin
        if (req_valid && (mode_req != mode_q)) begin
          target_d = mode_req;
          state_d  = ST_FADE_OUT;
        end
      end

      ST_FADE_OUT: begin
        if (req_valid) target_d = mode_req;
        // Zero gain here only happens when a fade-in is reversed before its first step.
        if (gain_q == '0) begin
          state_d = ST_SWITCH;
          mode_d  = target_d;
        end else if (step_now) begin
          gain_d = gain_q - 9'd1;
          if (gain_q == 9'd1) begin
            state_d = ST_SWITCH;
            mode_d  = target_d;
          end
        end else begin
          step_cnt_d = step_cnt_q + 16'd1;
        end
      end

      ST_SWITCH: begin
        if (settle_cnt_q == SETTLE_LAST) state_d = ST_FADE_IN;
        else settle_cnt_d = settle_cnt_q + 16'd1;
      end

      ST_FADE_IN: begin
        if (req_valid && (mode_req != mode_q)) begin
          target_d = mode_req;
          state_d  = ST_FADE_OUT;
        end else if (step_now) begin
          gain_d = gain_q + 9'd1;
          if (gain_q == (GAIN_ONE - 9'd1)) state_d = ST_RUN;
        end else begin
          step_cnt_d = step_cnt_q + 16'd1;
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      gain_q       <= GAIN_ONE;
      target_q     <= MODE_SIN;
      mode_q       <= MODE_SIN;
      step_cnt_q   <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      gain_q       <= gain_d;
      target_q     <= target_d;
      mode_q       <= mode_d;
      step_cnt_q   <= step_cnt_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  gain_scaler u_gain_scaler (
    .clk_100M (clk_100M),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .gain     (gain_q),
    .dac_data (dac_data)
  );

  assign mode = mode_q;
  assign busy = (state_q != ST_RUN);

endmodule
